mem_io_sequencer: RTL and testbench
===================================

Name: mem_io_sequencer

Overview:
- Parametrised successor to the fixed memory/I-O bridge between the SLC-3 datapath (MAR/MDR) and external SRAM.
- Adds the following over a fixed 4-digit bridge:
  - a configurable number of memory-mapped hex-display digits, switches and a LED register;
  - an SRAM access sequencer with programmable wait states;
  - an explicit ready handshake to the ISDU, so the control FSM stalls on memory instead of relying on fixed state counts.
- Sits between datapath/ISDU and the board SRAM and I/O.

Parameters:
- DATA_W, 16: CPU/SRAM data width.
- ADDR_W, 16: address width.
- NUM_HEX, 4: number of 7-segment digits. Constraint: 1..DATA_W/4.
- SW_W, 10: switch input width. Constraint: ≤ DATA_W.
- LED_W, 10: LED register width. Constraint: ≤ DATA_W.
- WAIT_CYCLES, 2: extra SRAM cycles per access. Range 0..15.
- IO_HEX_SW_ADDR, 16'hFFFF: read returns switches; write loads hex register.
- IO_LED_ADDR, 16'hFFFE: read/write the LED register.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous active-high reset
- Rd_Req  in  1  CPU read request, level, held until Mem_Ready
- Wr_Req  in  1  CPU write request, level, held until Mem_Ready
- ADDR  in  ADDR_W  address (from MAR)
- Data_from_CPU  in  DATA_W  write data (from MDR)
- Data_to_CPU  out  DATA_W  registered read data (to MDR mux)
- Mem_Ready  out  1  one-cycle completion pulse to ISDU
- SW  in  SW_W  board switches
- LED  out  LED_W  LED register
- HEX  out  7*NUM_HEX  segments, digit i at [7i+6:7i], active-low
- SRAM_ADDR  out  ADDR_W  registered SRAM address
- Data_to_SRAM  out  DATA_W  registered write data
- Data_from_SRAM  in  DATA_W  SRAM read data
- SRAM_OE_N  out  1  output enable, active-low
- SRAM_WE_N  out  1  write enable, active-low

Behaviour:

Reset:
- Reset asserted forces the following asynchronously: state IDLE, counter 0, Data_to_CPU 0, Mem_Ready 0, LED 0, hex register 0 (HEX shows "0" on all digits), SRAM_ADDR 0, Data_to_SRAM 0, SRAM_OE_N 1, SRAM_WE_N 1.
- Reset mid-access aborts the access. Strobes are high on the same edge; no Mem_Ready is produced.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- On the rising edge where Rd_Req|Wr_Req is sampled, latch ADDR, Data_from_CPU and op. If both requests are high, Wr_Req has priority.
- If ADDR matches IO_HEX_SW_ADDR or IO_LED_ADDR: perform the I/O op on that edge and go to DONE. SRAM strobes never assert.
  - Read of IO_HEX_SW_ADDR: Data_to_CPU = zero-extended SW.
  - Read of IO_LED_ADDR: Data_to_CPU = zero-extended LED.
  - Write of IO_HEX_SW_ADDR: hex register = Data_from_CPU[4*NUM_HEX-1:0].
  - Write of IO_LED_ADDR: LED = Data_from_CPU[LED_W-1:0].
- Otherwise: load counter = WAIT_CYCLES and go to ACCESS.

ACCESS:
- Lasts exactly WAIT_CYCLES+1 cycles.
- SRAM_OE_N = 0 throughout for reads; SRAM_WE_N = 0 throughout for writes. The other strobe stays 1.
- SRAM_ADDR and Data_to_SRAM are stable for the whole state.
- Counter decrements each cycle.
- On the edge leaving ACCESS (counter == 0): for reads, capture Data_from_SRAM into Data_to_CPU. Go to DONE.

DONE:
- Mem_Ready = 1 for exactly one cycle, then IDLE.
- Strobes are deasserted, registered, on entry to DONE.
- The requester must drop its request in the cycle Mem_Ready is high. A request still high in IDLE starts a new access; this is not an error.

Latency (request first sampled at edge k):
- I/O: Mem_Ready is high in the cycle after edge k.
- SRAM: Mem_Ready is high in the cycle after edge k+WAIT_CYCLES+1.

Other rules:
- Data_to_CPU holds its value until the next completed read; writes do not change it.
- HEX digit i is decoded from hex register bits [4i+3:4i] (0-F), through the existing HexDriver.
- All outputs are registered except HEX, which is combinational decode of the register.

Decomposition:
- Package mem_io_pkg:
  - state enum (IDLE, ACCESS, DONE);
  - op enum (OP_RD, OP_WR);
  - default I/O address constants.
- Sub-module mem_wait_fsm: FSM plus wait counter, producing strobe/capture/ready.
- Top module: address decode, I/O registers, data registers, NUM_HEX HexDriver instances via generate.

Test Plan:
1. Reset with Reset=1 mid-ACCESS (WAIT_CYCLES=2, read pending) -> SRAM_OE_N=1 and Mem_Ready=0 immediately; LED=0; all HEX=7'b1000000; no Mem_Ready after release.
2. Read 16'h3000, SRAM returns 16'hBEEF, WAIT_CYCLES=2 -> SRAM_OE_N low for exactly 3 cycles, SRAM_WE_N=1, Mem_Ready one cycle later, Data_to_CPU=16'hBEEF.
3. Write 16'h1234 to 16'h0042, WAIT_CYCLES=0 -> SRAM_WE_N low 1 cycle, SRAM_ADDR=16'h0042, Data_to_SRAM=16'h1234, Mem_Ready next cycle, Data_to_CPU unchanged.
4. Write 16'hA5C3 to 16'hFFFF with NUM_HEX=4 -> no strobe; Mem_Ready one cycle after the request; HEX digits 3..0 decode A,5,C,3. Then read 16'hFFFF with SW=10'h2AB -> Data_to_CPU=16'h02AB.
5. Write 16'h03FF to 16'hFFFE, then read 16'hFFFE -> LED=10'h3FF, Data_to_CPU=16'h03FF.
6. Rd_Req and Wr_Req both high to 16'h0010 -> write performed (SRAM_WE_N low, SRAM_OE_N high). Request held after Mem_Ready -> a second access starts from IDLE.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory/I-O sequencer.
//   state_t : sequencer states (IDLE, ACCESS, DONE)
//   op_t    : latched operation kind (OP_RD, OP_WR)
//   default memory-mapped I/O addresses and the wait-counter width
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [15:0] IO_HEX_SW_ADDR_DEF = 16'hFFFF;
  localparam logic [15:0] IO_LED_ADDR_DEF    = 16'hFFFE;

  // Wide enough for WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/HexDriver.sv
// 4-bit to 7-segment decoder for the board's common-anode displays.
//   In0  : nibble to display (0-F)
//   Out0 : segments {g,f,e,d,c,b,a}, active-low
module HexDriver (
  input  logic [3:0] In0,
  output logic [6:0] Out0
);

  always_comb begin
    unique case (In0)
      4'h0: Out0 = 7'b1000000;
      4'h1: Out0 = 7'b1111001;
      4'h2: Out0 = 7'b0100100;
      4'h3: Out0 = 7'b0110000;
      4'h4: Out0 = 7'b0011001;
      4'h5: Out0 = 7'b0010010;
      4'h6: Out0 = 7'b0000010;
      4'h7: Out0 = 7'b1111000;
      4'h8: Out0 = 7'b0000000;
      4'h9: Out0 = 7'b0010000;
      4'hA: Out0 = 7'b0001000;
      4'hB: Out0 = 7'b0000011;
      4'hC: Out0 = 7'b1000110;
      4'hD: Out0 = 7'b0100001;
      4'hE: Out0 = 7'b0000110;
      default: Out0 = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/mem_wait_fsm.sv
// Access sequencer: IDLE -> (ACCESS for WAIT_CYCLES+1 cycles) -> DONE -> IDLE.
//   Clk, Reset      : clock, asynchronous active-high reset
//   rd_req, wr_req  : level requests from the CPU (write wins if both high)
//   io_hit          : current address is a memory-mapped I/O register
//   accept          : request sampled this cycle (top latches address/data)
//   op_wr           : operation being accepted/executed is a write
//   capture         : last ACCESS cycle of a read; top captures SRAM data
//   ready           : registered one-cycle completion pulse (high in DONE)
//   oe_n, we_n      : registered SRAM strobes, active-low
module mem_wait_fsm
  import mem_io_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic rd_req,
  input  logic wr_req,
  input  logic io_hit,
  output logic accept,
  output logic op_wr,
  output logic capture,
  output logic ready,
  output logic oe_n,
  output logic we_n
);

  state_t           state, state_d;
  op_t              op, op_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             oe_n_d, we_n_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      op    <= OP_RD;
      cnt   <= '0;
      ready <= 1'b0;
      oe_n  <= 1'b1;
      we_n  <= 1'b1;
    end else begin
      state <= state_d;
      op    <= op_d;
      cnt   <= cnt_d;
      ready <= (state_d == DONE);
      oe_n  <= oe_n_d;
      we_n  <= we_n_d;
    end
  end

  always_comb begin
    state_d = state;
    op_d    = op;
    cnt_d   = cnt;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_req || wr_req) begin
          accept = 1'b1;
          op_d   = wr_req ? OP_WR : OP_RD;
          if (io_hit) begin
            state_d = DONE;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_d = DONE;
          capture = (op == OP_RD);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes are the registered image of the next state, so they are
    // low for exactly the cycles spent in ACCESS and high again in DONE.
    oe_n_d = !((state_d == ACCESS) && (op_d == OP_RD));
    we_n_d = !((state_d == ACCESS) && (op_d == OP_WR));
    op_wr  = (op_d == OP_WR);
  end

endmodule

// File: rtl/mem_io_sequencer.sv
// Memory / I-O bridge between the SLC-3 datapath (MAR/MDR) and board SRAM,
// with memory-mapped switches, LED register and hex display, programmable
// SRAM wait states and a Mem_Ready handshake to the ISDU.
//   Clk, Reset          : clock, asynchronous active-high reset
//   Rd_Req, Wr_Req      : CPU requests, held until Mem_Ready
//   ADDR, Data_from_CPU : address (MAR) and write data (MDR)
//   Data_to_CPU         : registered read data
//   Mem_Ready           : one-cycle completion pulse
//   SW, LED, HEX        : switches, LED register, 7-seg digits (active-low)
//   SRAM_ADDR, Data_to_SRAM, Data_from_SRAM, SRAM_OE_N, SRAM_WE_N : SRAM side
module mem_io_sequencer
  import mem_io_pkg::*;
#(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 16,
  parameter int                NUM_HEX        = 4,
  parameter int                SW_W           = 10,
  parameter int                LED_W          = 10,
  parameter int                WAIT_CYCLES    = 2,
  parameter logic [ADDR_W-1:0] IO_HEX_SW_ADDR = ADDR_W'(IO_HEX_SW_ADDR_DEF),
  parameter logic [ADDR_W-1:0] IO_LED_ADDR    = ADDR_W'(IO_LED_ADDR_DEF)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Rd_Req,
  input  logic                 Wr_Req,
  input  logic [ADDR_W-1:0]    ADDR,
  input  logic [DATA_W-1:0]    Data_from_CPU,
  output logic [DATA_W-1:0]    Data_to_CPU,
  output logic                 Mem_Ready,
  input  logic [SW_W-1:0]      SW,
  output logic [LED_W-1:0]     LED,
  output logic [7*NUM_HEX-1:0] HEX,
  output logic [ADDR_W-1:0]    SRAM_ADDR,
  output logic [DATA_W-1:0]    Data_to_SRAM,
  input  logic [DATA_W-1:0]    Data_from_SRAM,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N
);

  logic                 io_hex, io_led, io_hit;
  logic                 accept, op_wr, capture;
  logic [4*NUM_HEX-1:0] hex_reg;

  assign io_hex = (ADDR == IO_HEX_SW_ADDR);
  assign io_led = (ADDR == IO_LED_ADDR);
  assign io_hit = io_hex || io_led;

  mem_wait_fsm #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_fsm (
    .Clk     (Clk),
    .Reset   (Reset),
    .rd_req  (Rd_Req),
    .wr_req  (Wr_Req),
    .io_hit  (io_hit),
    .accept  (accept),
    .op_wr   (op_wr),
    .capture (capture),
    .ready   (Mem_Ready),
    .oe_n    (SRAM_OE_N),
    .we_n    (SRAM_WE_N)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data_to_CPU  <= '0;
      LED          <= '0;
      hex_reg      <= '0;
      SRAM_ADDR    <= '0;
      Data_to_SRAM <= '0;
    end else begin
      // SRAM-side registers only move for SRAM accesses, so an I/O cycle
      // never disturbs the address/data the SRAM last saw.
      if (accept && !io_hit) begin
        SRAM_ADDR    <= ADDR;
        Data_to_SRAM <= Data_from_CPU;
      end
      if (accept && io_hit) begin
        if (op_wr) begin
          if (io_hex) hex_reg <= Data_from_CPU[4*NUM_HEX-1:0];
          else        LED     <= Data_from_CPU[LED_W-1:0];
        end else begin
          Data_to_CPU <= io_hex ? DATA_W'(SW) : DATA_W'(LED);
        end
      end
      if (capture) Data_to_CPU <= Data_from_SRAM;
    end
  end

  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    HexDriver u_hex (
      .In0  (hex_reg[4*i +: 4]),
      .Out0 (HEX[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_mem_io_sequencer.sv
module tb_mem_io_sequencer;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Rd_Req = 1'b0, Wr_Req = 1'b0;
  logic        Rd_Req0 = 1'b0, Wr_Req0 = 1'b0;
  logic [15:0] ADDR = '0, Data_from_CPU = '0, Data_from_SRAM = '0;
  logic [9:0]  SW = '0;

  logic [15:0] Data_to_CPU, SRAM_ADDR, Data_to_SRAM;
  logic        Mem_Ready, SRAM_OE_N, SRAM_WE_N;
  logic [9:0]  LED;
  logic [27:0] HEX;

  logic [15:0] Data_to_CPU0, SRAM_ADDR0, Data_to_SRAM0;
  logic        Mem_Ready0, SRAM_OE_N0, SRAM_WE_N0;
  logic [9:0]  LED0;
  logic [27:0] HEX0;

  int checks = 0, errors = 0, cyc = 0;
  int oe_cnt = 0, we_cnt = 0, oe0_cnt = 0, we0_cnt = 0;
  exp_t qm[$], qz[$];

  localparam logic [27:0] HEX_ZERO  = {4{7'b1000000}};
  localparam logic [27:0] HEX_A5C3  = {7'b0001000, 7'b0010010, 7'b1000110, 7'b0110000};

  mem_io_sequencer #(.WAIT_CYCLES(2)) u_dut (
    .Clk(Clk), .Reset(Reset), .Rd_Req(Rd_Req), .Wr_Req(Wr_Req), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready),
    .SW(SW), .LED(LED), .HEX(HEX), .SRAM_ADDR(SRAM_ADDR), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
  );

  mem_io_sequencer #(.WAIT_CYCLES(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Rd_Req(Rd_Req0), .Wr_Req(Wr_Req0), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU0), .Mem_Ready(Mem_Ready0),
    .SW(SW), .LED(LED0), .HEX(HEX0), .SRAM_ADDR(SRAM_ADDR0), .Data_to_SRAM(Data_to_SRAM0),
    .Data_from_SRAM(Data_from_SRAM), .SRAM_OE_N(SRAM_OE_N0), .SRAM_WE_N(SRAM_WE_N0)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Strobe-low cycle counters, sampled mid-cycle.
  always @(negedge Clk) begin
    if (!SRAM_OE_N)  oe_cnt++;
    if (!SRAM_WE_N)  we_cnt++;
    if (!SRAM_OE_N0) oe0_cnt++;
    if (!SRAM_WE_N0) we0_cnt++;
  end

  // Scoreboard monitors: every Mem_Ready pulse must match the oldest
  // expected completion (read data and the cycle it appears in).
  always @(negedge Clk) begin
    if (!Reset && Mem_Ready) begin
      if (qm.size() == 0) begin
        chk("main_unexpected_ready", 32'(Mem_Ready), 32'h0);
      end else begin
        exp_t e;
        e = qm.pop_front();
        chk("main_data", 32'(Data_to_CPU), 32'(e.data));
        chk("main_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge Clk) begin
    if (!Reset && Mem_Ready0) begin
      if (qz.size() == 0) begin
        chk("w0_unexpected_ready", 32'(Mem_Ready0), 32'h0);
      end else begin
        exp_t e;
        e = qz.pop_front();
        chk("w0_data", 32'(Data_to_CPU0), 32'(e.data));
        chk("w0_ready_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One request/response transaction; lat = cycles from issue to the
  // negedge where Mem_Ready is seen (I/O: 1, SRAM: WAIT_CYCLES+2).
  task automatic xfer(input bit sel0, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_data, input int lat);
    exp_t e;
    int   n;
    @(negedge Clk);
    oe_cnt = 0; we_cnt = 0; oe0_cnt = 0; we0_cnt = 0;
    ADDR = a;
    Data_from_CPU = d;
    e.data = exp_data;
    e.cyc  = cyc + lat;
    if (sel0) begin
      qz.push_back(e);
      Rd_Req0 = rd; Wr_Req0 = wr;
    end else begin
      qm.push_back(e);
      Rd_Req = rd; Wr_Req = wr;
    end
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!(sel0 ? Mem_Ready0 : Mem_Ready) && n < 40);
    if (n >= 40) chk("xfer_timeout", 32'(n), 32'(lat));
    Rd_Req = 0; Wr_Req = 0; Rd_Req0 = 0; Wr_Req0 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_data", 32'(Data_to_CPU), 32'h0);
    chk("rst_ready", 32'(Mem_Ready), 32'h0);
    chk("rst_strobes", {30'h0, SRAM_OE_N, SRAM_WE_N}, 32'h3);
    chk("rst_sram_addr", 32'(SRAM_ADDR), 32'h0);
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_hex", 32'(HEX), 32'(HEX_ZERO));
    chk("rst_hex_w0", 32'(HEX0), 32'(HEX_ZERO));
    chk("rst_led_w0", 32'(LED0), 32'h0);
    Reset = 1'b0;

    // 1: reset in the middle of a read access
    @(negedge Clk);
    ADDR = 16'h3000; Data_from_SRAM = 16'h1111; Rd_Req = 1;
    @(posedge Clk); @(posedge Clk); #1;
    chk("t1_oe_in_access", 32'(SRAM_OE_N), 32'h0);
    #2 Reset = 1'b1;
    #1;
    chk("t1_oe_after_reset", 32'(SRAM_OE_N), 32'h1);
    chk("t1_ready_after_reset", 32'(Mem_Ready), 32'h0);
    chk("t1_led", 32'(LED), 32'h0);
    chk("t1_hex", 32'(HEX), 32'(HEX_ZERO));
    Rd_Req = 0;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (8) @(negedge Clk);
    chk("t1_data_kept_zero", 32'(Data_to_CPU), 32'h0);

    // 2: SRAM read, 2 wait states
    Data_from_SRAM = 16'hBEEF;
    xfer(0, 1, 0, 16'h3000, 16'h0000, 16'hBEEF, 4);
    chk("t2_oe_cycles", 32'(oe_cnt), 32'd3);
    chk("t2_we_cycles", 32'(we_cnt), 32'd0);
    chk("t2_sram_addr", 32'(SRAM_ADDR), 32'h3000);
    chk("t2_strobes_idle", {30'h0, SRAM_OE_N, SRAM_WE_N}, 32'h3);

    // 3: zero wait states on the second instance
    Data_from_SRAM = 16'hCAFE;
    xfer(1, 1, 0, 16'h0005, 16'h0000, 16'hCAFE, 2);
    chk("t3_rd_oe_cycles", 32'(oe0_cnt), 32'd1);
    xfer(1, 0, 1, 16'h0042, 16'h1234, 16'hCAFE, 2);
    chk("t3_we_cycles", 32'(we0_cnt), 32'd1);
    chk("t3_oe_cycles", 32'(oe0_cnt), 32'd0);
    chk("t3_sram_addr", 32'(SRAM_ADDR0), 32'h0042);
    chk("t3_sram_wdata", 32'(Data_to_SRAM0), 32'h1234);

    // 4: hex write and switch read
    xfer(0, 0, 1, 16'hFFFF, 16'hA5C3, 16'hBEEF, 1);
    chk("t4_no_strobe", 32'(oe_cnt + we_cnt), 32'd0);
    chk("t4_hex", 32'(HEX), 32'(HEX_A5C3));
    chk("t4_sram_addr_untouched", 32'(SRAM_ADDR), 32'h3000);
    SW = 10'h2AB;
    xfer(0, 1, 0, 16'hFFFF, 16'h0000, 16'h02AB, 1);
    chk("t4_rd_no_strobe", 32'(oe_cnt + we_cnt), 32'd0);

    // 5: LED write and read-back
    xfer(0, 0, 1, 16'hFFFE, 16'h03FF, 16'h02AB, 1);
    chk("t5_led", 32'(LED), 32'h3FF);
    xfer(0, 1, 0, 16'hFFFE, 16'h0000, 16'h03FF, 1);

    // 6: both requests high, held past Mem_Ready -> two writes
    begin
      exp_t e;
      int   n, seen;
      @(negedge Clk);
      oe_cnt = 0; we_cnt = 0;
      ADDR = 16'h0010; Data_from_CPU = 16'h5A5A;
      Rd_Req = 1; Wr_Req = 1;
      e.data = 16'h03FF; e.cyc = cyc + 4; qm.push_back(e);
      e.data = 16'h03FF; e.cyc = cyc + 9; qm.push_back(e);
      n = 0; seen = 0;
      while (seen < 2 && n < 60) begin
        @(negedge Clk);
        n++;
        if (Mem_Ready) seen++;
      end
      if (n >= 60) chk("t6_timeout", 32'(seen), 32'd2);
      Rd_Req = 0; Wr_Req = 0;
      chk("t6_we_cycles", 32'(we_cnt), 32'd6);
      chk("t6_oe_cycles", 32'(oe_cnt), 32'd0);
      chk("t6_sram_addr", 32'(SRAM_ADDR), 32'h0010);
      chk("t6_sram_wdata", 32'(Data_to_SRAM), 32'h5A5A);
    end

    repeat (6) @(negedge Clk);
    chk("end_main_queue_empty", 32'(qm.size()), 32'd0);
    chk("end_w0_queue_empty", 32'(qz.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
